dlfloat_accum_ctrl: RTL and testbench

// - Sequencing controller that reduces a stream of LEN DLfloat16 operands (1s/6e/9m, bias 31) to one sum.
// - Sits beside dlfloat_adder: upstream of it (drives add_a/add_b) and downstream of it (captures add_c).
// - Presents the final sum on a valid/ready result port.
// - Adder latency is one clock (registered c). The adder's active-low reset is tied to ~rst at integration.

---
 rtl/dlfloat_pkg.sv | 26 ++
 rtl/dlfloat_accum_ctrl.sv | 154 +++++++++++++++
 tb/tb_dlfloat_accum_ctrl.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/dlfloat_pkg.sv
// Shared DLfloat16 definitions: field widths, packed layout and zero test.
package dlfloat_pkg;

  localparam int DLF_W = 16;
  localparam int EXP_W = 6;
  localparam int MAN_W = 9;
  localparam int BIAS  = 31;
  localparam logic [EXP_W-1:0] EXP_MAX = 6'h3F;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } dlf_t;

  // An all-zero exponent field flushes the value to zero regardless of mantissa.
  function automatic logic dlf_is_zero(input dlf_t v);
    return (v.exp == {EXP_W{1'b0}});
  endfunction

  // Exponent saturated at its maximum encoding.
  function automatic logic dlf_is_exp_max(input dlf_t v);
    return (v.exp == EXP_MAX);
  endfunction

endpackage

// File: rtl/dlfloat_accum_ctrl.sv
// Reduction controller: folds LEN DLfloat16 operands into one sum using an
// external one-cycle adder, then presents the sum on a valid/ready port.
// All outputs are registers loaded from the next-state values.
module dlfloat_accum_ctrl
  import dlfloat_pkg::*;
#(
  parameter  int LEN   = 8,
  localparam int CNT_W = $clog2(LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DLF_W-1:0] in_data,
  output logic [DLF_W-1:0] add_a,
  output logic [DLF_W-1:0] add_b,
  input  logic [DLF_W-1:0] add_c,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DLF_W-1:0] out_data,
  output logic             out_ovf,
  output logic             busy
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ACC   = 3'd1,
    S_ISSUE = 3'd2,
    S_CAPT  = 3'd3,
    S_CHECK = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] LEN_C  = CNT_W'(LEN);
  localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);
  localparam logic [CNT_W-1:0] ZERO_C = CNT_W'(0);
  localparam logic [DLF_W-1:0] DLF_ZERO = 16'h0000;

  state_t           state_r, next_state_s;
  logic [DLF_W-1:0] acc_r, acc_s;
  logic [DLF_W-1:0] opb_r, opb_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic             ovf_r, ovf_s;
  logic             in_ready_r, out_valid_r, busy_r;
  logic [DLF_W-1:0] add_a_r, add_b_r, out_data_r;
  logic             transfer_s, consume_s;

  assign transfer_s = in_valid & in_ready_r;
  assign consume_s  = out_valid_r & out_ready;

  // Next-state and next-datapath values for every controller register.
  always_comb begin
    next_state_s = state_r;
    acc_s        = acc_r;
    opb_s        = opb_r;
    cnt_s        = cnt_r;
    ovf_s        = ovf_r;
    case (state_r)
      S_IDLE: begin
        if (transfer_s) begin
          acc_s        = in_data;
          cnt_s        = ONE_C;
          next_state_s = (LEN == 1) ? S_DONE : S_ACC;
        end else begin
          next_state_s = S_IDLE;
        end
      end
      S_ACC: begin
        if (transfer_s) begin
          cnt_s = cnt_r + ONE_C;
          if (dlf_is_zero(dlf_t'(in_data))) begin
            next_state_s = S_CHECK;
          end else if (dlf_is_zero(dlf_t'(acc_r))) begin
            // Running sum is still zero: adopt the operand without an adder pass.
            acc_s        = in_data;
            next_state_s = S_CHECK;
          end else begin
            opb_s        = in_data;
            next_state_s = S_ISSUE;
          end
        end else begin
          next_state_s = S_ACC;
        end
      end
      S_ISSUE: begin
        next_state_s = S_CAPT;
      end
      S_CAPT: begin
        acc_s        = add_c;
        ovf_s        = ovf_r | dlf_is_exp_max(dlf_t'(add_c));
        next_state_s = S_CHECK;
      end
      S_CHECK: begin
        if (cnt_r == LEN_C) begin
          next_state_s = S_DONE;
        end else begin
          next_state_s = S_ACC;
        end
      end
      S_DONE: begin
        if (consume_s) begin
          ovf_s        = 1'b0;
          cnt_s        = ZERO_C;
          acc_s        = DLF_ZERO;
          next_state_s = S_IDLE;
        end else begin
          next_state_s = S_DONE;
        end
      end
      default: begin
        next_state_s = S_IDLE;
      end
    endcase
  end

  // State, datapath and registered output update; reset discards any partial sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= S_IDLE;
      acc_r       <= DLF_ZERO;
      opb_r       <= DLF_ZERO;
      cnt_r       <= ZERO_C;
      ovf_r       <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      add_a_r     <= DLF_ZERO;
      add_b_r     <= DLF_ZERO;
      out_data_r  <= DLF_ZERO;
    end else begin
      state_r     <= next_state_s;
      acc_r       <= acc_s;
      opb_r       <= opb_s;
      cnt_r       <= cnt_s;
      ovf_r       <= ovf_s;
      in_ready_r  <= (next_state_s == S_IDLE) || (next_state_s == S_ACC);
      out_valid_r <= (next_state_s == S_DONE);
      busy_r      <= (next_state_s != S_IDLE);
      // Adder operands are driven only in ISSUE so the adder rests at zero.
      add_a_r     <= (next_state_s == S_ISSUE) ? acc_s : DLF_ZERO;
      add_b_r     <= (next_state_s == S_ISSUE) ? opb_s : DLF_ZERO;
      out_data_r  <= (next_state_s == S_DONE) ? acc_s : DLF_ZERO;
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign add_a     = add_a_r;
  assign add_b     = add_b_r;
  assign out_data  = out_data_r;
  assign out_ovf   = ovf_r;

endmodule

// File: tb/tb_dlfloat_accum_ctrl.sv
// Self-checking bench: two controllers (LEN=4 and LEN=1), each beside a
// stub adder (c <= a + b, one cycle, reset to 0), checked against a
// reduction model built from the operand rules.
module tb_dlfloat_accum_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        in_valid = 1'b0, in_ready;
  logic [15:0] in_data = 16'h0000;
  logic [15:0] add_a, add_b, add_c;
  logic        out_valid, out_ready = 1'b0, out_ovf, busy;
  logic [15:0] out_data;

  logic        in_valid1 = 1'b0, in_ready1;
  logic [15:0] in_data1 = 16'h0000;
  logic [15:0] add_a1, add_b1, add_c1;
  logic        out_valid1, out_ready1 = 1'b0, out_ovf1, busy1;
  logic [15:0] out_data1;

  int checks = 0;
  int errors = 0;
  int issues1 = 0;
  logic [31:0] pairs[$];
  logic [31:0] exp_pairs[$];

  always #5 clk = ~clk;

  dlfloat_accum_ctrl #(.LEN(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .add_a(add_a), .add_b(add_b), .add_c(add_c), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_ovf(out_ovf), .busy(busy)
  );

  dlfloat_accum_ctrl #(.LEN(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
    .add_a(add_a1), .add_b(add_b1), .add_c(add_c1), .out_valid(out_valid1),
    .out_ready(out_ready1), .out_data(out_data1), .out_ovf(out_ovf1), .busy(busy1)
  );

  // Stub adders with one-cycle registered result.
  always @(posedge clk) begin
    add_c  <= rst ? 16'h0000 : add_a + add_b;
    add_c1 <= rst ? 16'h0000 : add_a1 + add_b1;
  end

  // Record every adder issue (any non-zero operand pair) once per cycle.
  always @(negedge clk) begin
    if (add_a != 16'h0000 || add_b != 16'h0000) pairs.push_back({add_a, add_b});
    if (add_a1 != 16'h0000 || add_b1 != 16'h0000) issues1 = issues1 + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic is_zero(input logic [15:0] v);
    return v[14:9] == 6'h00;
  endfunction

  // Reference reduction: zero operands skipped, zero sum replaced, else add.
  task automatic model(input logic [15:0] ops[4], output logic [15:0] sum, output logic ovf);
    sum = ops[0];
    ovf = 1'b0;
    for (int i = 1; i < 4; i++) begin
      if (is_zero(ops[i])) begin
        sum = sum;
      end else if (is_zero(sum)) begin
        sum = ops[i];
      end else begin
        exp_pairs.push_back({sum, ops[i]});
        sum = sum + ops[i];
        if (sum[14:9] == 6'h3F) ovf = 1'b1;
      end
    end
  endtask

  // Offer one operand at a negedge, wait for acceptance, return at the next negedge.
  task automatic send(input logic [15:0] x);
    int n = 0;
    in_valid = 1'b1;
    in_data  = x;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("send_accept", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 16'h0000;
  endtask

  // Wait for the result, check it and its stability under back-pressure, then consume.
  task automatic finish_red(input string tag, input logic [15:0] esum, input logic eovf, input int hold);
    int n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_data"}, {16'd0, out_data}, {16'd0, esum});
    check({tag, "_ovf"}, {31'd0, out_ovf}, {31'd0, eovf});
    check({tag, "_npairs"}, pairs.size(), exp_pairs.size());
    for (int i = 0; i < pairs.size() && i < exp_pairs.size(); i++)
      check({tag, "_pair"}, pairs[i], exp_pairs[i]);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check({tag, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
      check({tag, "_hold_data"}, {16'd0, out_data}, {16'd0, esum});
      check({tag, "_hold_ready"}, {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_cons_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_cons_ovf"}, {31'd0, out_ovf}, 32'd0);
    check({tag, "_cons_ready"}, {31'd0, in_ready}, 32'd1);
    check({tag, "_cons_busy"}, {31'd0, busy}, 32'd0);
    pairs.delete();
    exp_pairs.delete();
  endtask

  task automatic reduce(input string tag, input logic [15:0] ops[4], input int gap, input int hold);
    logic [15:0] esum;
    logic        eovf;
    model(ops, esum, eovf);
    for (int i = 0; i < 4; i++) begin
      send(ops[i]);
      repeat (gap) @(negedge clk);
    end
    finish_red(tag, esum, eovf, hold);
  endtask

  initial begin
    logic [15:0] ops[4];
    logic [31:0] r;
    int n;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_ready", {31'd0, in_ready}, 32'd1);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_data", {16'd0, out_data}, 32'd0);
    check("rst_ovf", {31'd0, out_ovf}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_adda", {16'd0, add_a}, 32'd0);

    // Four equal operands, no gaps.
    ops = '{16'h3E00, 16'h3E00, 16'h3E00, 16'h3E00};
    reduce("four", ops, 0, 0);

    // Zero operands bypass the adder.
    ops = '{16'h3E00, 16'h0000, 16'h3E00, 16'h0000};
    reduce("zero_skip", ops, 0, 0);

    // Exponent saturation sets the sticky flag; back-pressure for 5 cycles.
    ops = '{16'h3F00, 16'h3F00, 16'h0000, 16'h0000};
    reduce("ovf_hold", ops, 1, 5);

    // Reset during CAPT of element 3 discards the partial sum.
    send(16'h3E00);
    send(16'h3E00);
    send(16'h3E00);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_ready", {31'd0, in_ready}, 32'd1);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_data", {16'd0, out_data}, 32'd0);
    check("mid_rst_ovf", {31'd0, out_ovf}, 32'd0);
    check("mid_rst_add", {add_a, add_b}, 32'd0);
    pairs.delete();
    ops = '{16'h3E00, 16'h3E00, 16'h3E00, 16'h3E00};
    reduce("after_rst", ops, 0, 0);

    // Randomised reductions with zero-exponent operands mixed in.
    for (int t = 0; t < 25; t++) begin
      for (int i = 0; i < 4; i++) begin
        r = $urandom;
        if (r[20:19] == 2'b00) ops[i] = {r[15], 6'h00, r[8:0]};
        else ops[i] = r[15:0];
      end
      reduce("rand", ops, $urandom_range(0, 2), $urandom_range(0, 3));
    end

    // LEN=1 controller: single operand, no adder issue.
    in_valid1 = 1'b1;
    in_data1  = 16'h4200;
    check("len1_ready", {31'd0, in_ready1}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid1 = 1'b0;
    in_data1  = 16'h0000;
    n = 0;
    while (!out_valid1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("len1_valid", {31'd0, out_valid1}, 32'd1);
    check("len1_data", {16'd0, out_data1}, 32'h4200);
    check("len1_issues", issues1, 32'd0);
    out_ready1 = 1'b1;
    @(negedge clk);
    out_ready1 = 1'b0;
    check("len1_cons_valid", {31'd0, out_valid1}, 32'd0);
    check("len1_cons_ready", {31'd0, in_ready1}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
